// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, frame lengths and FSM encoding for the UART memory-command initiator.
package uart_cmd_pkg;

  localparam logic [2:0] OP_BRAM_WR  = 3'd1;
  localparam logic [2:0] OP_BRAM_RD  = 3'd2;
  localparam logic [2:0] OP_SPRAM_WR = 3'd3;
  localparam logic [2:0] OP_SPRAM_RD = 3'd4;
  localparam logic [2:0] OP_WARMBOOT = 3'd5;

  localparam logic [2:0] LEN_WRITE    = 3'd6;
  localparam logic [2:0] LEN_READ     = 3'd4;
  localparam logic [2:0] LEN_WARMBOOT = 3'd2;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT_ACK,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DONE
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op >= OP_BRAM_WR) && (op <= OP_WARMBOOT);
  endfunction

  function automatic logic op_is_write(input logic [2:0] op);
    return (op == OP_BRAM_WR) || (op == OP_SPRAM_WR);
  endfunction

  function automatic logic [2:0] frame_len(input logic [2:0] op);
    case (op)
      OP_BRAM_WR, OP_SPRAM_WR: return LEN_WRITE;
      OP_BRAM_RD, OP_SPRAM_RD: return LEN_READ;
      OP_WARMBOOT:             return LEN_WARMBOOT;
      default:                 return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_frame_mux.sv
// Combinational command-frame byte selector: picks the byte for the current index
// and flags the final byte of the frame for the latched opcode.
module uart_cmd_frame_mux
  import uart_cmd_pkg::*;
#(
  parameter int MEM_SELECT_BITS = 5
) (
  input  logic [2:0]                 op,
  input  logic [MEM_SELECT_BITS-1:0] select,
  input  logic [13:0]                addr,
  input  logic [15:0]                wdata,
  input  logic [2:0]                 index,
  output logic [7:0]                 frame_byte,
  output logic                       last
);

  logic is_spram;

  assign is_spram = (op == OP_SPRAM_WR) || (op == OP_SPRAM_RD);
  assign last     = (index == (frame_len(op) - 3'd1));

  always_comb begin
    frame_byte = 8'h00;
    case (index)
      3'd0: frame_byte = {5'b0, op};
      3'd1: frame_byte = 8'(select);
      // BRAM only decodes the low address byte, so its high byte is forced to zero
      3'd2: frame_byte = is_spram ? {2'b00, addr[13:8]} : 8'h00;
      3'd3: frame_byte = addr[7:0];
      3'd4: frame_byte = wdata[15:8];
      3'd5: frame_byte = wdata[7:0];
      default: frame_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/uart_cmd_initiator.sv
// Host-side UART memory-command master: serializes one command, then collects its response.
// Optional macro RESPONSE_TIMEOUT_EN adds a response wait limit of TIMEOUT_CYCLES clocks.
module uart_cmd_initiator
  import uart_cmd_pkg::*;
#(
  parameter int         MEM_SELECT_BITS = 5,
  parameter logic [7:0] ACK_BYTE        = DEFAULT_ACK_BYTE,
  parameter int         TIMEOUT_CYCLES  = 4_800_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_op,
  input  logic [MEM_SELECT_BITS-1:0] cmd_select,
  input  logic [13:0]                cmd_addr,
  input  logic [15:0]                cmd_wdata,
  output logic                       rsp_valid,
  output logic [15:0]                rsp_rdata,
  output logic                       rsp_error,
  output logic [7:0]                 tx_data,
  output logic                       tx_en,
  input  logic                       tx_busy,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       busy
);

  if ((MEM_SELECT_BITS < 1) || (MEM_SELECT_BITS > 8) || (TIMEOUT_CYCLES < 1) ||
      (TIMEOUT_CYCLES > (1 << 23))) begin : g_bad_params
    $error("uart_cmd_initiator: MEM_SELECT_BITS or TIMEOUT_CYCLES out of range");
  end

  state_t                     state, state_next;
  logic [2:0]                 op_q, idx_q;
  logic [MEM_SELECT_BITS-1:0] select_q;
  logic [13:0]                addr_q;
  logic [15:0]                wdata_q;
  logic [7:0]                 rdata_hi_q;
  logic [7:0]                 frame_byte;
  logic                       frame_last;
  logic                       accept, tx_fire, rsp_load, rsp_error_d, timed_out;
  logic [15:0]                rsp_rdata_d;
  logic                       in_wait;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign in_wait   = (state == ST_WAIT_ACK) || (state == ST_WAIT_HI) || (state == ST_WAIT_LO);

  uart_cmd_frame_mux #(.MEM_SELECT_BITS(MEM_SELECT_BITS)) u_frame_mux (
    .op         (op_q),
    .select     (select_q),
    .addr       (addr_q),
    .wdata      (wdata_q),
    .index      (idx_q),
    .frame_byte (frame_byte),
    .last       (frame_last)
  );

`ifdef RESPONSE_TIMEOUT_EN
  logic [22:0] wait_cnt;

  // Cleared every GAP cycle so it always starts at zero on entry to a wait state
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              wait_cnt <= '0;
    else if (state == ST_GAP) wait_cnt <= '0;
    else if (in_wait)       wait_cnt <= wait_cnt + 23'd1;
  end

  assign timed_out = in_wait && (wait_cnt >= 23'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    tx_fire     = 1'b0;
    rsp_load    = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = 16'h0000;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (op_is_legal(cmd_op)) begin
            state_next = ST_SEND;
          end else begin
            state_next  = ST_DONE;
            rsp_load    = 1'b1;
            rsp_error_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          tx_fire    = 1'b1;
          state_next = ST_GAP;
        end
      end
      // uart_tx raises busy a cycle after the strobe, so busy is ignored here
      ST_GAP: begin
        if (!frame_last) begin
          state_next = ST_SEND;
        end else if (op_q == OP_WARMBOOT) begin
          state_next = ST_DONE;
          rsp_load   = 1'b1;
        end else if (op_is_write(op_q)) begin
          state_next = ST_WAIT_ACK;
        end else begin
          state_next = ST_WAIT_HI;
        end
      end
      ST_WAIT_ACK: begin
        if (rx_valid) begin
          state_next  = ST_DONE;
          rsp_load    = 1'b1;
          rsp_error_d = (rx_data != ACK_BYTE);
        end else if (timed_out) begin
          state_next  = ST_DONE;
          rsp_load    = 1'b1;
          rsp_error_d = 1'b1;
        end
      end
      ST_WAIT_HI: begin
        if (rx_valid) begin
          state_next = ST_WAIT_LO;
        end else if (timed_out) begin
          state_next  = ST_DONE;
          rsp_load    = 1'b1;
          rsp_error_d = 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (rx_valid) begin
          state_next  = ST_DONE;
          rsp_load    = 1'b1;
          rsp_rdata_d = {rdata_hi_q, rx_data};
        end else if (timed_out) begin
          state_next  = ST_DONE;
          rsp_load    = 1'b1;
          rsp_error_d = 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q       <= '0;
      select_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      rdata_hi_q <= '0;
      tx_data    <= '0;
      tx_en      <= 1'b0;
      rsp_error  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      tx_en <= tx_fire;
      if (accept) begin
        op_q     <= cmd_op;
        select_q <= cmd_select;
        addr_q   <= cmd_addr;
        wdata_q  <= cmd_wdata;
        idx_q    <= 3'd0;
      end
      if (tx_fire)                      tx_data    <= frame_byte;
      if ((state == ST_GAP) && !frame_last) idx_q  <= idx_q + 3'd1;
      if ((state == ST_WAIT_HI) && rx_valid) rdata_hi_q <= rx_data;
      if (rsp_load) begin
        rsp_error <= rsp_error_d;
        rsp_rdata <= rsp_rdata_d;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Directed scoreboard bench for uart_cmd_initiator: a uart_tx busy model feeds back
// tx_busy, and a negedge monitor checks every tx byte and response against queued expectations.
module tb_uart_cmd_initiator;
  import uart_cmd_pkg::*;

  localparam int SEL_W = 5;

  typedef struct packed {
    logic        err;
    logic [15:0] rdata;
  } rsp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [SEL_W-1:0] cmd_select;
  logic [13:0]      cmd_addr;
  logic [15:0]      cmd_wdata;
  logic             rsp_valid;
  logic [15:0]      rsp_rdata;
  logic             rsp_error;
  logic [7:0]       tx_data;
  logic             tx_en;
  logic             tx_busy;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             busy;

  logic [7:0] tx_q[$];
  rsp_t       rsp_q[$];
  rsp_t       mon_rsp;
  int         checks_total  = 0;
  int         checks_passed = 0;
  int         checks_failed = 0;
  int         busy_cnt;
  logic       prev_busy  = 1'b0;
  logic       prev_tx_en = 1'b0;

  uart_cmd_initiator #(
    .MEM_SELECT_BITS (SEL_W),
    .ACK_BYTE        (8'hAA),
    .TIMEOUT_CYCLES  (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_select (cmd_select),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_error  (rsp_error),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_busy    (tx_busy),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy for three cycles starting the cycle after each strobe
  always @(posedge clk or posedge reset) begin
    if (reset)             busy_cnt <= 0;
    else if (tx_en)        busy_cnt <= 3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_en) begin
        checkOutput("tx_busy_before_strobe", 32'(prev_busy), 32'd0);
        checkOutput("tx_en_single_pulse", 32'(prev_tx_en), 32'd0);
        checkOutput("tx_expected", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) checkOutput("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
      end
      if (rsp_valid) begin
        checkOutput("rsp_ready_overlap", 32'(cmd_ready), 32'd0);
        checkOutput("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          mon_rsp = rsp_q.pop_front();
          checkOutput("rsp_error", 32'(rsp_error), 32'(mon_rsp.err));
          checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(mon_rsp.rdata));
        end
      end
    end
    prev_busy  = tx_busy;
    prev_tx_en = tx_en;
  end

  task automatic pushRsp(input logic err, input logic [15:0] rdata);
    rsp_t r;
    r.err   = err;
    r.rdata = rdata;
    rsp_q.push_back(r);
  endtask

  // Queues the expected frame, then holds cmd_valid until the accepting edge has passed
  task automatic applyStimulus(input logic [2:0] op, input logic [SEL_W-1:0] sel,
                               input logic [13:0] addr, input logic [15:0] wdata);
    logic [7:0] f[6];
    int n;
    n = ((op == 3'd1) || (op == 3'd3)) ? 6 :
        ((op == 3'd2) || (op == 3'd4)) ? 4 : (op == 3'd5) ? 2 : 0;
    f[0] = {5'b0, op};
    f[1] = 8'(sel);
    f[2] = ((op == 3'd3) || (op == 3'd4)) ? {2'b00, addr[13:8]} : 8'h00;
    f[3] = addr[7:0];
    f[4] = wdata[15:8];
    f[5] = wdata[7:0];
    for (int i = 0; i < n; i++) tx_q.push_back(f[i]);
    cmd_op     = op;
    cmd_select = sel;
    cmd_addr   = addr;
    cmd_wdata  = wdata;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic sendRx(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic waitTx(input int limit);
    for (int i = 0; i < limit && tx_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("tx_drain", 32'(tx_q.size()), 32'd0);
  endtask

  task automatic waitRsp(input int limit);
    for (int i = 0; i < limit && rsp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("rsp_drain", 32'(rsp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_select = '0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_tx_en", 32'(tx_en), 32'd0);
    checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("reset_rsp_error", 32'(rsp_error), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] BRAM write acked");
    pushRsp(1'b0, 16'h0000);
    applyStimulus(3'd1, 5'h03, 14'h002A, 16'hBEEF);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    waitTx(200);
    sendRx(8'hAA);
    waitRsp(20);

    $display("[TB] SPRAM read");
    pushRsp(1'b0, 16'h5AC3);
    applyStimulus(3'd4, 5'h00, 14'h1234, 16'h0000);
    waitTx(200);
    sendRx(8'h5A);
    sendRx(8'hC3);
    waitRsp(20);

    $display("[TB] SPRAM write nacked with stray rx during send");
    pushRsp(1'b1, 16'h0000);
    applyStimulus(3'd3, 5'h1F, 14'h3FFF, 16'h0001);
    sendRx(8'hAA);
    @(posedge clk); #1;
    sendRx(8'h5A);
    waitTx(200);
    sendRx(8'h55);
    waitRsp(20);

    $display("[TB] warmboot");
    pushRsp(1'b0, 16'h0000);
    applyStimulus(3'd5, 5'h02, 14'h0000, 16'h0000);
    waitTx(100);
    waitRsp(10);

    $display("[TB] illegal opcodes");
    pushRsp(1'b1, 16'h0000);
    applyStimulus(3'd7, 5'h01, 14'h0001, 16'h0001);
    checkOutput("illegal_rsp_latency", 32'(rsp_valid), 32'd1);
    waitRsp(10);
    pushRsp(1'b1, 16'h0000);
    applyStimulus(3'd0, 5'h00, 14'h0000, 16'h0000);
    waitRsp(10);

    $display("[TB] reset mid-frame");
    applyStimulus(3'd1, 5'h04, 14'h0011, 16'h1234);
    for (int i = 0; i < 200 && tx_q.size() > 3; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_frame_progress", 32'(tx_q.size()), 32'd3);
    reset = 1'b1;
    #1;
    checkOutput("abort_tx_en", 32'(tx_en), 32'd0);
    checkOutput("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    tx_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abort_idle", 32'(busy), 32'd0);

    $display("[TB] BRAM read after abort");
    pushRsp(1'b0, 16'h1234);
    applyStimulus(3'd2, 5'h01, 14'h3F77, 16'h0000);
    waitTx(200);
    sendRx(8'h12);
    sendRx(8'h34);
    waitRsp(20);

`ifdef RESPONSE_TIMEOUT_EN
    $display("[TB] read with no reply");
    begin
      int waited;
      pushRsp(1'b1, 16'h0000);
      applyStimulus(3'd2, 5'h01, 14'h0005, 16'h0000);
      waitTx(200);
      waited = 0;
      while (!rsp_valid && waited < 300) begin
        @(posedge clk); #1;
        waited++;
      end
      checkOutput("timeout_latency", 32'(waited), 32'd100);
      waitRsp(10);
    end
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/uart_cmd_initiator.md
Name: uart_cmd_initiator

Overview:
Host-side master for the UART memory-access command protocol. It accepts one memory command per handshake and serializes it into command bytes for a byte-level uart_tx. It then collects the response bytes from a byte-level uart_rx and returns read data or a write status. It sits on a test/bridge FPGA, or in a synthesizable loopback bench, and drives a board running the memory controller over its UART pins.

Parameters:
MEM_SELECT_BITS, 5, width of memory-block select field (must be <= 8)
ACK_BYTE, 8'hAA, byte returned by the far end after a completed write
TIMEOUT_CYCLES, 4_800_000, response wait limit in clk cycles (used only with RESPONSE_TIMEOUT_EN)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE; a command is taken on cmd_valid&&cmd_ready
cmd_op  input  3  1=BRAM write, 2=BRAM read, 3=SPRAM write, 4=SPRAM read, 5=warmboot; others illegal
cmd_select  input  MEM_SELECT_BITS  block select (warmboot: bits[1:0] = boot image)
cmd_addr  input  14  BRAM uses [7:0]; SPRAM uses all 14 bits
cmd_wdata  input  16  write data
rsp_valid  output  1  one-cycle pulse, command finished
rsp_rdata  output  16  read data, valid with rsp_valid (0 for non-reads)
rsp_error  output  1  valid with rsp_valid
tx_data  output  8  byte to uart_tx
tx_en  output  1  one-cycle send strobe
tx_busy  input  1  uart_tx busy
rx_data  input  8  byte from uart_rx
rx_valid  input  1  one-cycle received-byte strobe
busy  output  1  high whenever state != IDLE

Behaviour:
- Single clock; async active-high reset. All outputs are 0 at reset except cmd_ready=1. State=IDLE.
- Accept: on cmd_valid&&cmd_ready, register op/select/addr/wdata. State goes to SEND with byte index=0. cmd_ready drops the next cycle.
- Illegal op (0,6,7): no bytes are sent. rsp_valid=1 with rsp_error=1 one cycle after accept; return to IDLE.
- Frame, in order:
  - byte0 = {5'b0, op}.
  - byte1 = select, zero-extended to 8 bits.
  - byte2 = {2'b0, addr[13:8]} (BRAM: 8'h00).
  - byte3 = addr[7:0].
  - byte4 = wdata[15:8], byte5 = wdata[7:0] (writes only).
  - Lengths: writes 6 bytes, reads 4 bytes, warmboot 2 bytes.
- TX handshake:
  - In SEND, when tx_busy==0, drive tx_data and pulse tx_en for exactly one cycle, then enter GAP for one cycle; tx_busy is not sampled during GAP.
  - Return to SEND with index+1, or leave after the last byte.
  - tx_data holds its value until the next strobe.
- After the last byte:
  - Warmboot: rsp_valid with rsp_error=0 next cycle, then IDLE (no response is expected).
  - Write: WAIT_ACK. The first rx_valid byte ends the command with rsp_error = (rx_data != ACK_BYTE).
  - Read: WAIT_HI, then WAIT_LO. Bytes are captured high then low; rsp_rdata={hi,lo}, rsp_valid in the cycle after the low byte, rsp_error=0.
- rx_valid in IDLE, SEND or GAP is ignored (dropped).
- rsp_rdata holds until the next rsp_valid.
- rsp_valid and cmd_ready are never high in the same cycle. The earliest new accept is the cycle after rsp_valid.
- Reset asserted mid-frame aborts immediately: tx_en=0, no rsp_valid, state=IDLE. A partially sent frame is not resumed.
- Byte index is 3 bits; it never exceeds 5.

Optional Feature:
RESPONSE_TIMEOUT_EN:
- Defined: a 23-bit counter clears on entry to WAIT_ACK/WAIT_HI and runs through WAIT_LO. On reaching TIMEOUT_CYCLES-1 with no completing byte, the command ends with rsp_valid=1, rsp_error=1, rsp_rdata=0, then IDLE. A byte arriving in the same cycle as expiry wins (normal completion).
- Undefined: no counter; the block waits forever for a response, and only reset recovers it.

Decomposition:
- Package uart_cmd_pkg: opcode localparams (OP_BRAM_WR..OP_WARMBOOT), per-op frame lengths, default ACK_BYTE, state encoding.
- One sub-module: uart_cmd_frame_mux. It is combinational and maps {op, select, addr, wdata, index} to tx_data and the last-byte flag.

Test Plan:
- BRAM write op=1, select=3, addr=8'h2A, wdata=16'hBEEF -> tx bytes 01 03 00 2A BE EF, one tx_en each only while tx_busy=0. Reply AA -> rsp_valid, rsp_error=0.
- SPRAM read op=4, addr=14'h1234 -> tx 04 00 12 34. Reply 5A C3 -> rsp_rdata=16'h5AC3, rsp_error=0.
- Write answered with 8'h55 -> rsp_error=1. Stray rx bytes injected during SEND are ignored.
- Warmboot op=5, select=2 -> tx 05 02, then rsp_valid with no rx. Illegal op=7 -> no tx_en, rsp_error=1.
- Reset asserted after byte2 of a write -> tx_en stays 0, cmd_ready=1, no rsp_valid. The next read completes normally.
- With RESPONSE_TIMEOUT_EN and TIMEOUT_CYCLES=100, a read with no reply -> rsp_error=1 exactly 100 cycles after entering WAIT_HI.
